spi_cfg_regbank: RTL and testbench
==================================

// Module: spi_cfg_regbank
// PURPOSE
//  SPI-slave configuration front end of the LED controller: receives command/data bytes from the host
//  over SPI (mode 0, MSB first, DC line selects command vs data), writes data bytes into an 8x8-bit
//  register bank (CONF_WR) or streams the bank back on MISO (CONF_RD). Bank drives downstream channel config.
// PARAMETERS
//  REG_NUM      8      number of 8-bit config registers (address width $clog2(REG_NUM) = 3)
//  CMD_CONF_WR  8'h2A  command: write registers from address 0 upward
//  CMD_CONF_RD  8'h2D  command: read registers from address 0 upward
// PORTS
//  clk_i       in   1          system clock (nominal 200 MHz); single clock domain
//  rst_n_i     in   1          reset, asynchronous, active-low
//  dc_i        in   1          0 = command byte, 1 = data byte; sampled at each byte's 8th SCLK rising edge
//  spi_sclk_i  in   1          SPI clock, async to clk_i, idle low
//  spi_mosi_i  in   1          SPI data in, changes on SCLK fall, sampled on SCLK rise
//  spi_cs_n_i  in   1          SPI chip select, active-low
//  spi_miso_o  out  1          SPI data out, MSB first
//  cfg_o       out  8*REG_NUM  register bank, reg k at cfg_o[8k+7:8k]
// BEHAVIOUR
//  - Reset: all registers 8'h00, cfg_o = 0, spi_miso_o = 0, state IDLE, bit count 0, addresses 0.
//  - sclk/mosi/cs_n/dc_i pass 2-FF synchronizers; SCLK edges detected in clk_i domain.
//    SCLK high and low phases each >= 4 clk_i cycles.
//  - cs_n high (synced): bit count 0, state IDLE, no byte events; rising cs_n mid-byte discards partial byte.
//  - Each detected SCLK rise with cs_n low: shift mosi into rx[0] (MSB first), bit count +1 mod 8;
//    on the 8th bit a 1-clk byte_vld pulse is issued on the next clk with byte and synced dc.
//  - Controller states: IDLE, WR, RD. On byte_vld with dc=0: 0x2A -> WR, wr_addr=0; 0x2D -> RD, rd_addr=0;
//    any other -> IDLE. Command bytes are never written to the bank.
//  - WR, byte_vld, dc=1: reg[wr_addr] <= byte one clk later, wr_addr+1; bytes beyond REG_NUM ignored
//    (no write, no wrap). IDLE/RD data bytes ignored (mosi in RD is don't-care).
//  - RD: each data-byte completion (byte_vld, dc=1) advances rd_addr by 1;
//    rd_addr >= REG_NUM reads 8'h00.
//  - MISO: tx shift reg loaded with reg[rd_addr] (8'h00 when not RD) on first SCLK fall of each byte
//    (bit count 0); shifted left on the other SCLK falls; spi_miso_o = tx[7]. Byte after CONF_RD returns
//    reg0, then reg1... Read data registered, combinational path from bank to tx load only.
//  - Write and read of same address in same clk: read returns old value.
//  - dc_i changing mid-byte: only value at 8th rise matters.
// CONFIGURATION
//  SPI_MISO_TRISTATE_EN: defined -> spi_miso_o = 1'bz while synced cs_n high, tx[7] otherwise.
//    Undefined -> spi_miso_o always driven (0 while cs_n high, reset 0).
// STRUCTURE
//  Package spi_cfg_pkg: CMD_CONF_WR/CMD_CONF_RD localparams, ctl_state_t enum {IDLE,WR,RD},
//    reg address typedef.
//  Sub-module spi_byte_if: synchronizers, edge detect, rx/tx shift, bit count, byte_vld.
//  Command decode and register array live in top module.
// TESTING (clk 5 ns, SCLK half period 60 ns)
//  1 Reset -> cfg_o=0, spi_miso_o=0; CONF_RD + 8 data bytes -> MISO returns 8'h00 x8.
//  2 cs_n low, dc=0, send 0x2A; dc=1, send 10 bytes 0xFF -> reg0..7=8'hFF, cfg_o='1, bytes 9-10 dropped.
//  3 After 2: dc=0 send 0x2D; dc=1 send 10 x 0x00 -> MISO bytes FF x8, then 00 x2; bank unchanged.
//  4 Write 0x2A then 01,02,03 -> reg0..2=01,02,03, rest unchanged; then CONF_RD reads 01,02,03 in order.
//  5 Unknown command 0x55 then data 0xAA -> no register change; MISO 00.
//  6 cs_n deassert after 4 bits, reassert, send 0x2A + 0x5A -> partial byte discarded, reg0=0x5A;
//    rst_n_i low mid-transfer -> all state and cfg_o to 0 immediately.

Source files
------------

// File: rtl/spi_cfg_pkg.sv
// Shared constants and types for the SPI configuration register bank.
package spi_cfg_pkg;

  localparam int unsigned REG_NUM = 8;
  localparam int unsigned ADDR_W  = $clog2(REG_NUM);
  // Pointer carries one extra bit so it can sit at REG_NUM without wrapping
  localparam int unsigned PTR_W   = ADDR_W + 1;

  localparam logic [7:0] CMD_CONF_WR = 8'h2A;
  localparam logic [7:0] CMD_CONF_RD = 8'h2D;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2
  } ctl_state_t;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [PTR_W-1:0]  reg_ptr_t;

  // Completed SPI byte handed from the byte interface to the controller
  typedef struct packed {
    logic       vld;
    logic       dc;
    logic [7:0] data;
  } byte_evt_t;

  // True while a pointer still addresses a real register
  function automatic logic ptr_in_range(input reg_ptr_t p);
    return p < reg_ptr_t'(REG_NUM);
  endfunction

endpackage

// File: rtl/spi_byte_if.sv
// SPI mode-0 slave byte interface: synchronizers, SCLK edge detect,
// MSB-first rx/tx shifting and a one-clock byte event.
module spi_byte_if
  import spi_cfg_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       sclk_i,
  input  logic       mosi_i,
  input  logic       cs_n_i,
  input  logic       dc_i,
  input  logic [7:0] tx_load_c_i,
  output byte_evt_t  evt_o,
  output logic       cs_n_o,
  output logic       miso_o
);

  // Sync bit order: {sclk, mosi, cs_n, dc}; cs_n idles high out of reset
  localparam logic [3:0] SYNC_RST = 4'b0010;

  logic [3:0] sync1_q, sync1_d;
  logic [3:0] sync2_q, sync2_d;
  logic       sclk_prev_q, sclk_prev_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] rx_q, rx_d;
  logic [7:0] tx_q, tx_d;
  byte_evt_t  evt_q, evt_d;

  logic sclk_s, mosi_s, cs_n_s, dc_s;
  logic sclk_rise, sclk_fall;

  assign sclk_s    = sync2_q[3];
  assign mosi_s    = sync2_q[2];
  assign cs_n_s    = sync2_q[1];
  assign dc_s      = sync2_q[0];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;

  // Next-state: sync pipeline, bit counting, shifting and byte event
  always_comb begin
    sync1_d     = {sclk_i, mosi_i, cs_n_i, dc_i};
    sync2_d     = sync1_q;
    sclk_prev_d = sclk_s;
    bit_cnt_d   = bit_cnt_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    evt_d       = '0;
    if (cs_n_s) begin
      bit_cnt_d = 3'd0;
      tx_d      = 8'h00;
    end else begin
      if (sclk_rise) begin
        rx_d      = {rx_q[6:0], mosi_s};
        bit_cnt_d = 3'(bit_cnt_q + 3'd1);
        if (bit_cnt_q == 3'd7) begin
          evt_d.vld  = 1'b1;
          evt_d.dc   = dc_s;
          evt_d.data = rx_d;
        end
      end
      // Fall with count 0 ends the previous byte: present next byte's MSB
      if (sclk_fall) begin
        if (bit_cnt_q == 3'd0) tx_d = tx_load_c_i;
        else                   tx_d = {tx_q[6:0], 1'b0};
      end
    end
  end

  // Interface registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync1_q     <= SYNC_RST;
      sync2_q     <= SYNC_RST;
      sclk_prev_q <= 1'b0;
      bit_cnt_q   <= 3'd0;
      rx_q        <= 8'h00;
      tx_q        <= 8'h00;
      evt_q       <= '0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      sclk_prev_q <= sclk_prev_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      evt_q       <= evt_d;
    end
  end

  assign evt_o  = evt_q;
  assign cs_n_o = cs_n_s;
  assign miso_o = tx_q[7];

endmodule

// File: rtl/spi_cfg_regbank.sv
// SPI-slave configuration register bank: CONF_WR fills registers from
// address 0, CONF_RD streams them back on MISO.
// Build option: SPI_MISO_TRISTATE_EN floats spi_miso_o while cs_n is high.
module spi_cfg_regbank
  import spi_cfg_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 dc_i,
  input  logic                 spi_sclk_i,
  input  logic                 spi_mosi_i,
  input  logic                 spi_cs_n_i,
  output logic                 spi_miso_o,
  output logic [8*REG_NUM-1:0] cfg_o
);

  ctl_state_t               state_q, state_d;
  reg_ptr_t                 wr_addr_q, wr_addr_d;
  reg_ptr_t                 rd_addr_q, rd_addr_d;
  logic [REG_NUM-1:0][7:0]  regs_q, regs_d;

  byte_evt_t  evt;
  logic       cs_n_s;
  logic       miso;
  logic [7:0] rd_data_c;

  spi_byte_if u_byte_if (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .sclk_i      (spi_sclk_i),
    .mosi_i      (spi_mosi_i),
    .cs_n_i      (spi_cs_n_i),
    .dc_i        (dc_i),
    .tx_load_c_i (rd_data_c),
    .evt_o       (evt),
    .cs_n_o      (cs_n_s),
    .miso_o      (miso)
  );

  // Read data for the next tx load; registers hold old value on same-cycle write
  always_comb begin
    rd_data_c = 8'h00;
    if (state_q == RD && ptr_in_range(rd_addr_q))
      rd_data_c = regs_q[reg_addr_t'(rd_addr_q[ADDR_W-1:0])];
  end

  // Command decode, register writes and read pointer advance
  always_comb begin
    state_d   = state_q;
    wr_addr_d = wr_addr_q;
    rd_addr_d = rd_addr_q;
    regs_d    = regs_q;
    if (evt.vld) begin
      if (!evt.dc) begin
        case (evt.data)
          CMD_CONF_WR: begin
            state_d   = WR;
            wr_addr_d = '0;
          end
          CMD_CONF_RD: begin
            state_d   = RD;
            rd_addr_d = '0;
          end
          default: state_d = IDLE;
        endcase
      end else begin
        case (state_q)
          WR: if (ptr_in_range(wr_addr_q)) begin
            regs_d[reg_addr_t'(wr_addr_q[ADDR_W-1:0])] = evt.data;
            wr_addr_d = wr_addr_q + reg_ptr_t'(1);
          end
          RD: if (ptr_in_range(rd_addr_q)) rd_addr_d = rd_addr_q + reg_ptr_t'(1);
          default: ;
        endcase
      end
    end
    if (cs_n_s) state_d = IDLE;
  end

  // Controller state, pointers and register bank
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      wr_addr_q <= '0;
      rd_addr_q <= '0;
      regs_q    <= '0;
    end else begin
      state_q   <= state_d;
      wr_addr_q <= wr_addr_d;
      rd_addr_q <= rd_addr_d;
      regs_q    <= regs_d;
    end
  end

  assign cfg_o = regs_q;

`ifdef SPI_MISO_TRISTATE_EN
  assign spi_miso_o = cs_n_s ? 1'bz : miso;
`else
  assign spi_miso_o = miso;
`endif

endmodule

// File: tb/tb_spi_cfg_regbank.sv
// Directed bench for spi_cfg_regbank: host-side SPI driver, a byte-level
// model of the command protocol, and a queue of expected MISO bytes.
`timescale 1ns/100ps
module tb_spi_cfg_regbank;

  localparam int unsigned HALF = 60;

  logic        clk_i;
  logic        rst_n_i;
  logic        dc_i;
  logic        spi_sclk_i;
  logic        spi_mosi_i;
  logic        spi_cs_n_i;
  logic        spi_miso_o;
  logic [63:0] cfg_o;

  int checks;
  int failures;

  logic [7:0] m_regs [8];
  int         m_st;
  int         m_wr;
  int         m_rd;
  logic [7:0] m_next_miso;
  logic [7:0] exp_q [$];

  spi_cfg_regbank dut (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .dc_i       (dc_i),
    .spi_sclk_i (spi_sclk_i),
    .spi_mosi_i (spi_mosi_i),
    .spi_cs_n_i (spi_cs_n_i),
    .spi_miso_o (spi_miso_o),
    .cfg_o      (cfg_o)
  );

  initial clk_i = 1'b0;
  always #2.5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model_cfg();
    logic [63:0] v;
    v = '0;
    for (int k = 0; k < 8; k++) v[8*k +: 8] = m_regs[k];
    return v;
  endfunction

  // Host view of the protocol, applied after each completed byte
  task automatic model_byte(input logic dc, input logic [7:0] data);
    if (!dc) begin
      if (data == 8'h2A) begin m_st = 1; m_wr = 0; end
      else if (data == 8'h2D) begin m_st = 2; m_rd = 0; end
      else m_st = 0;
    end else if (m_st == 1) begin
      if (m_wr < 8) begin m_regs[m_wr] = data; m_wr++; end
    end else if (m_st == 2) begin
      if (m_rd < 8) m_rd++;
    end
    m_next_miso = (m_st == 2 && m_rd < 8) ? m_regs[m_rd] : 8'h00;
  endtask

  task automatic spi_byte(input logic dc, input logic [7:0] data, output logic [7:0] got);
    got  = 8'h00;
    dc_i = dc;
    for (int i = 7; i >= 0; i--) begin
      spi_mosi_i = data[i];
      #HALF spi_sclk_i = 1'b1;
      got[i] = spi_miso_o;
      #HALF spi_sclk_i = 1'b0;
    end
  endtask

  task automatic spi_bits(input logic [7:0] data, input int n);
    for (int i = 0; i < n; i++) begin
      spi_mosi_i = data[7-i];
      #HALF spi_sclk_i = 1'b1;
      #HALF spi_sclk_i = 1'b0;
    end
  endtask

  // One byte: queue the expected MISO byte, transfer, then score it
  task automatic xfer(input logic dc, input logic [7:0] data);
    logic [7:0] got;
    exp_q.push_back(m_next_miso);
    spi_byte(dc, data, got);
    model_byte(dc, data);
    check(dc ? "miso_data" : "miso_cmd", {56'h0, got}, {56'h0, exp_q.pop_front()});
  endtask

  task automatic cs_lo();
    spi_cs_n_i  = 1'b0;
    m_next_miso = 8'h00;
    m_st        = 0;
    #100;
  endtask

  task automatic cs_hi();
    #HALF spi_cs_n_i = 1'b1;
    m_st = 0;
    #100;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 8; k++) m_regs[k] = 8'h00;
    m_st = 0; m_wr = 0; m_rd = 0;
    m_next_miso = 8'h00;
  endtask

  initial begin
    checks = 0; failures = 0;
    model_reset();
    rst_n_i = 1'b0; dc_i = 1'b0; spi_sclk_i = 1'b0; spi_mosi_i = 1'b0; spi_cs_n_i = 1'b1;
    #50;
    check("reset_cfg", cfg_o, 64'h0);
    check("reset_miso", {63'h0, spi_miso_o}, 64'h0);
    rst_n_i = 1'b1;
    #50;

    // 1: read back a freshly reset bank
    cs_lo();
    xfer(1'b0, 8'h2D);
    for (int i = 0; i < 8; i++) xfer(1'b1, 8'h00);
    cs_hi();
    check("idle_miso", {63'h0, spi_miso_o}, 64'h0);

    // 2: fill with FF, extra bytes dropped
    cs_lo();
    xfer(1'b0, 8'h2A);
    for (int i = 0; i < 10; i++) xfer(1'b1, 8'hFF);
    cs_hi();
    check("wr_ff_cfg", cfg_o, 64'hFFFF_FFFF_FFFF_FFFF);
    check("wr_ff_model", cfg_o, model_cfg());

    // 3: read past the end returns 00, bank untouched
    cs_lo();
    xfer(1'b0, 8'h2D);
    for (int i = 0; i < 10; i++) xfer(1'b1, 8'h00);
    cs_hi();
    check("rd_ff_cfg", cfg_o, 64'hFFFF_FFFF_FFFF_FFFF);

    // 4: partial write then read-back in the same session
    cs_lo();
    xfer(1'b0, 8'h2A);
    xfer(1'b1, 8'h01);
    xfer(1'b1, 8'h02);
    xfer(1'b1, 8'h03);
    xfer(1'b0, 8'h2D);
    for (int i = 0; i < 3; i++) xfer(1'b1, 8'h00);
    cs_hi();
    check("wr3_cfg", cfg_o, 64'hFFFF_FFFF_FF03_0201);

    // 5: unknown command leaves bank alone
    cs_lo();
    xfer(1'b0, 8'h55);
    xfer(1'b1, 8'hAA);
    cs_hi();
    check("unk_cfg", cfg_o, 64'hFFFF_FFFF_FF03_0201);

    // 6: aborted half byte is discarded
    cs_lo();
    dc_i = 1'b0;
    spi_bits(8'hB7, 4);
    cs_hi();
    cs_lo();
    xfer(1'b0, 8'h2A);
    xfer(1'b1, 8'h5A);
    cs_hi();
    check("abort_cfg", cfg_o, 64'hFFFF_FFFF_FF03_025A);
    check("abort_model", cfg_o, model_cfg());

    // Reset in the middle of a transfer clears everything at once
    cs_lo();
    spi_bits(8'h2A, 5);
    rst_n_i = 1'b0;
    #1;
    check("midrst_cfg", cfg_o, 64'h0);
    check("midrst_miso", {63'h0, spi_miso_o}, 64'h0);
    #4;
    spi_cs_n_i = 1'b1;
    #20;
    rst_n_i = 1'b1;
    model_reset();
    #50;

    // Bank usable again after reset
    cs_lo();
    xfer(1'b0, 8'h2A);
    xfer(1'b1, 8'hC3);
    xfer(1'b0, 8'h2D);
    xfer(1'b1, 8'h00);
    xfer(1'b1, 8'h00);
    cs_hi();
    check("post_rst_cfg", cfg_o, 64'h0000_0000_0000_00C3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
